// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: default datapath width, NOP encoding and
// the PC+instruction bundle carried between pipeline queues.
package pipeline_defs;

  localparam int unsigned WIDTH_DEF = 16;

  localparam logic [WIDTH_DEF-1:0] NOP_DEF = 16'h0000;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] pc;
    logic [WIDTH_DEF-1:0] ins;
  } fetch_pair_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// IF/ID queue storage: DEPTH x 2*WIDTH array, one write port,
// one asynchronous read port, no reset.
module if_id_queue_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [2*WIDTH-1:0] rdata
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID queue: DEPTH-entry in-order FIFO of {PC, instruction} between
// fetch and decode, first-word fall-through, flush and sticky overflow.
module if_id_queue
  import pipeline_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP = WIDTH'(NOP_DEF),
  localparam int unsigned CW = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WRITE_ENABLE,
  input  logic [WIDTH-1:0] PROGRAM_COUNTER,
  input  logic [WIDTH-1:0] INSTRUCTION,
  input  logic             READ_ENABLE,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] PROGRAM_COUNTER_OUT,
  output logic [WIDTH-1:0] INSTRUCTION_OUT,
  output logic             VALID_OUT,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic               pop;
  logic               push;
  logic               drop;
  logic               mem_we;
  logic [2*WIDTH-1:0] rdata;

  assign VALID_OUT = (count_q != '0);
  assign FULL      = (count_q == CW'(DEPTH));

  always_comb begin
    pop      = READ_ENABLE && VALID_OUT;
    push     = WRITE_ENABLE && (!FULL || pop);
    drop     = WRITE_ENABLE && !push;
    mem_we   = push && !FLUSH;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  if_id_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata ({PROGRAM_COUNTER, INSTRUCTION}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Empty slots present a bubble, never stale storage.
  always_comb begin
    if (VALID_OUT) begin
      PROGRAM_COUNTER_OUT = rdata[2*WIDTH-1:WIDTH];
      INSTRUCTION_OUT     = rdata[WIDTH-1:0];
    end else begin
      PROGRAM_COUNTER_OUT = '0;
      INSTRUCTION_OUT     = NOP;
    end
  end

  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed plan steps plus random
// traffic, checked against a queue-based reference model.
module tb_if_id_queue;
  import pipeline_defs::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] NOP = 16'h0000;

  logic             CLK;
  logic             RST_N;
  logic             WRITE_ENABLE;
  logic [WIDTH-1:0] PROGRAM_COUNTER;
  logic [WIDTH-1:0] INSTRUCTION;
  logic             READ_ENABLE;
  logic             FLUSH;
  logic [WIDTH-1:0] PROGRAM_COUNTER_OUT;
  logic [WIDTH-1:0] INSTRUCTION_OUT;
  logic             VALID_OUT;
  logic             FULL;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;

  int checks = 0;
  int errors = 0;

  fetch_pair_t mq[$];
  bit          movf;

  if_id_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NOP   (NOP)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .WRITE_ENABLE        (WRITE_ENABLE),
    .PROGRAM_COUNTER     (PROGRAM_COUNTER),
    .INSTRUCTION         (INSTRUCTION),
    .READ_ENABLE         (READ_ENABLE),
    .FLUSH               (FLUSH),
    .PROGRAM_COUNTER_OUT (PROGRAM_COUNTER_OUT),
    .INSTRUCTION_OUT     (INSTRUCTION_OUT),
    .VALID_OUT           (VALID_OUT),
    .FULL                (FULL),
    .COUNT               (COUNT),
    .OVERFLOW            (OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    bit          ne;
    fetch_pair_t h;
    ne = (mq.size() != 0);
    h  = ne ? mq[0] : '{pc: 16'h0000, ins: NOP};
    chk({tag, ".valid"}, 32'(VALID_OUT), 32'(ne));
    chk({tag, ".pc"}, 32'(PROGRAM_COUNTER_OUT), 32'(h.pc));
    chk({tag, ".ins"}, 32'(INSTRUCTION_OUT), 32'(h.ins));
    chk({tag, ".count"}, 32'(COUNT), 32'(mq.size()));
    chk({tag, ".full"}, 32'(FULL), 32'(mq.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(OVERFLOW), 32'(movf));
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge.
  task automatic step(input string tag, input bit we,
                      input logic [15:0] pc, input logic [15:0] ins,
                      input bit re, input bit fl);
    bit mpop, mpush;
    WRITE_ENABLE    = we;
    PROGRAM_COUNTER = pc;
    INSTRUCTION     = ins;
    READ_ENABLE     = re;
    FLUSH           = fl;
    mpop  = re && (mq.size() != 0);
    mpush = we && ((mq.size() < DEPTH) || mpop);
    @(posedge CLK);
    #1;
    if (fl) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back('{pc: pc, ins: ins});
      if (we && !mpush) movf = 1'b1;
    end
    WRITE_ENABLE = 1'b0;
    READ_ENABLE  = 1'b0;
    FLUSH        = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    assert (DEPTH >= 2) else $fatal(1, "FAIL depth_param DEPTH=%0d", DEPTH);
    RST_N           = 1'b1;
    WRITE_ENABLE    = 1'b0;
    PROGRAM_COUNTER = '0;
    INSTRUCTION     = '0;
    READ_ENABLE     = 1'b0;
    FLUSH           = 1'b0;
    movf            = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    chk_model("reset");
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    step("push1", 1, 16'h0002, 16'hFFFF, 0, 0);
    chk("push1.pc_const", 32'(PROGRAM_COUNTER_OUT), 32'h0002);
    step("pop1", 0, 16'h0, 16'h0, 1, 0);

    step("fill_a", 1, 16'h0004, 16'hFFF2, 0, 0);
    step("fill_b", 1, 16'h0006, 16'hFFF3, 0, 0);
    chk("full_const", 32'(FULL), 32'h1);
    step("drop", 1, 16'h0008, 16'hFFF4, 0, 0);
    chk("drop.ovf_const", 32'(OVERFLOW), 32'h1);
    chk("drop.pc_const", 32'(PROGRAM_COUNTER_OUT), 32'h0004);

    step("full_pp", 1, 16'h000A, 16'hFFF5, 1, 0);
    chk("full_pp.pc_const", 32'(PROGRAM_COUNTER_OUT), 32'h0006);
    step("drain1", 0, 16'h0, 16'h0, 1, 0);
    chk("drain1.ins_const", 32'(INSTRUCTION_OUT), 32'hFFF5);
    step("drain2", 0, 16'h0, 16'h0, 1, 0);
    chk("drain2.ins_const", 32'(INSTRUCTION_OUT), 32'(NOP));

    step("refill_a", 1, 16'h0010, 16'h1111, 0, 0);
    step("refill_b", 1, 16'h0012, 16'h2222, 0, 0);
    step("flush", 1, 16'h000C, 16'hFFF6, 1, 1);
    chk("flush.count_const", 32'(COUNT), 32'h0);

    for (int i = 0; i < 3; i++) step("empty_rd", 0, 16'h0, 16'h0, 1, 0);
    step("after_empty", 1, 16'h000E, 16'h1234, 0, 0);
    chk("after_empty.ins_const", 32'(INSTRUCTION_OUT), 32'h1234);
    step("after_empty_pop", 0, 16'h0, 16'h0, 1, 0);

    step("async_a", 1, 16'h0020, 16'hAAAA, 0, 0);
    step("async_b", 1, 16'h0022, 16'hBBBB, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    mq.delete();
    movf = 1'b0;
    chk_model("async_rst");
    @(posedge CLK);
    #1 RST_N = 1'b1;

    step("wrap_seed", 1, 16'h0100, 16'h5000, 0, 0);
    for (int i = 1; i <= 4 * DEPTH + 1; i++) begin
      step("wrap", 1, 16'(16'h0100 + 2 * i), 16'(16'h5000 + i), 1, 0);
    end
    step("wrap_last", 0, 16'h0, 16'h0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
